// File: rtl/tc_ram_copy_pkg.sv
// Shared state encoding and default widths for the RAM copy engine.
package tc_ram_copy_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/tc_ram_copy_addr_gen.sv
// Word index counter with terminal-count detect and wrapped source/destination address sums.
module tc_ram_copy_addr_gen
  import tc_ram_copy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic [ADDR_WIDTH-1:0] src_next,
  output logic [ADDR_WIDTH-1:0] dst_cur,
  output logic [ADDR_WIDTH-1:0] dst_next,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] index_q;
  logic [ADDR_WIDTH-1:0] index_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q <= '0;
    end else if (clear) begin
      index_q <= '0;
    end else if (step) begin
      index_q <= index_inc;
    end
  end

  // Sums truncate to ADDR_WIDTH, so addresses wrap around the RAM.
  always_comb begin
    index_inc = index_q + ADDR_WIDTH'(1);
    src_next  = src_base + index_inc;
    dst_cur   = dst_base + index_q;
    dst_next  = dst_base + index_inc;
    last      = (index_inc == len);
  end

endmodule

// File: rtl/tc_ram_copy.sv
// Ascending-order RAM-to-RAM word copy engine, two cycles per word.
// Optional fill mode (constant write, one cycle per word) under `TC_RAM_COPY_FILL_EN.
module tc_ram_copy
  import tc_ram_copy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
`ifdef TC_RAM_COPY_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_value,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  ram_load,
  output logic                  ram_save,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] src_next;
  logic [ADDR_WIDTH-1:0] dst_cur;
  logic [ADDR_WIDTH-1:0] dst_next;
  logic                  last;
  logic                  accept;
  logic                  start_fill;
  logic                  fill_mode;
  logic [DATA_WIDTH-1:0] start_word;
  logic [DATA_WIDTH-1:0] fill_word;

`ifdef TC_RAM_COPY_FILL_EN
  logic                  fill_q;
  logic [DATA_WIDTH-1:0] fill_value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q       <= 1'b0;
      fill_value_q <= '0;
    end else if (accept) begin
      fill_q       <= fill;
      fill_value_q <= fill_value;
    end
  end

  assign start_fill = fill;
  assign start_word = fill_value;
  assign fill_mode  = fill_q;
  assign fill_word  = fill_value_q;
`else
  assign start_fill = 1'b0;
  assign start_word = '0;
  assign fill_mode  = 1'b0;
  assign fill_word  = '0;
`endif

  assign accept = (state_q == StIdle) && start;

  tc_ram_copy_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .step     (state_q == StWrite),
    .src_base (src_q),
    .dst_base (dst_q),
    .len      (len_q),
    .src_next (src_next),
    .dst_cur  (dst_cur),
    .dst_next (dst_next),
    .last     (last)
  );

  // Outputs are registered: each branch loads the values for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
    end else begin
      done        <= 1'b0;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            busy  <= 1'b1;
            if (len == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else if (start_fill) begin
              state_q     <= StWrite;
              ram_save    <= 1'b1;
              ram_address <= dst;
              ram_in      <= start_word;
            end else begin
              state_q     <= StRead;
              ram_load    <= 1'b1;
              ram_address <= src;
            end
          end
        end
        StRead: begin
          state_q     <= StWrite;
          ram_save    <= 1'b1;
          ram_address <= dst_cur;
          ram_in      <= ram_out;
        end
        StWrite: begin
          if (last) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else if (fill_mode) begin
            ram_save    <= 1'b1;
            ram_address <= dst_next;
            ram_in      <= fill_word;
          end else begin
            state_q     <= StRead;
            ram_load    <= 1'b1;
            ram_address <= src_next;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_ram_copy.sv
// Scoreboard bench for tc_ram_copy: a RAM model, a shadow copy and a queue of expected writes.
module tb_tc_ram_copy;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst, len;
  logic          busy, done, ram_load, ram_save;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in, ram_out;
`ifdef TC_RAM_COPY_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_value;
`endif

  logic [DW-1:0]    mem    [256];
  logic [DW-1:0]    shadow [256];
  logic [AW+DW-1:0] exp_q  [$];

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles, done_pulses, load_cycles, save_cycles;
  int overlap = 0;

  always #5 clk = ~clk;

  tc_ram_copy #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src         (src),
    .dst         (dst),
    .len         (len),
`ifdef TC_RAM_COPY_FILL_EN
    .fill        (fill),
    .fill_value  (fill_value),
`endif
    .busy        (busy),
    .done        (done),
    .ram_load    (ram_load),
    .ram_save    (ram_save),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_out     (ram_out)
  );

  always @(posedge clk) if (ram_save) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every write and checks idle outputs.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_pulses++;
    if (ram_load === 1'b1) load_cycles++;
    if (ram_load === 1'b1 && ram_save === 1'b1) overlap++;
    if (ram_save === 1'b1) begin
      save_cycles++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_address), 32'(e[AW+DW-1:DW]));
        check("wr_data", 32'(ram_in), 32'(e[DW-1:0]));
      end
    end
    if (busy !== 1'b1 || done === 1'b1)
      check("idle_out_zero", {14'd0, ram_load, ram_save, ram_address, ram_in}, 32'd0);
  end

  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                     input bit f, input logic [DW-1:0] fv, input int exp_lat, input bit restart);
    int lat;
    for (int i = 0; i < int'(l); i++) begin
      logic [AW-1:0] sa, da;
      logic [DW-1:0] w;
      sa = s + AW'(i);
      da = d + AW'(i);
      w  = f ? fv : shadow[sa];
      shadow[da] = w;
      exp_q.push_back({da, w});
    end
    busy_cycles = 0; done_pulses = 0; load_cycles = 0; save_cycles = 0;
    src = s; dst = d; len = l; start = 1'b1;
`ifdef TC_RAM_COPY_FILL_EN
    fill = f; fill_value = fv;
`endif
    @(negedge clk);
    start = 1'b0;
    src = ~s; dst = ~d; len = l + 8'd3;
`ifdef TC_RAM_COPY_FILL_EN
    fill = ~f; fill_value = ~fv;
`endif
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      start = restart && (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    repeat (4) @(negedge clk);
    check("busy_cycles", 32'(busy_cycles), 32'(exp_lat));
    check("done_pulses", 32'(done_pulses), 32'd1);
    check("load_cycles", 32'(load_cycles), f ? 32'd0 : 32'(l));
    check("save_cycles", 32'(save_cycles), 32'(l));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int diffs;
    logic [AW-1:0] rs, rd, rl;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef TC_RAM_COPY_FILL_EN
    fill = 1'b0; fill_value = '0;
`endif
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      shadow[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-word copy
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03;
    shadow[8'h10] = 8'h01; shadow[8'h11] = 8'h02; shadow[8'h12] = 8'h03;
    run(8'h10, 8'h40, 8'd3, 1'b0, 8'h00, 7, 1'b0);
    check("copy_40", 32'(mem[8'h40]), 32'h01);
    check("copy_41", 32'(mem[8'h41]), 32'h02);
    check("copy_42", 32'(mem[8'h42]), 32'h03);

    // Zero-length
    run(8'h20, 8'h30, 8'd0, 1'b0, 8'h00, 1, 1'b0);

    // Wrap with forward overlap
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC;
    shadow[8'hFE] = 8'hAA; shadow[8'hFF] = 8'hBB; shadow[8'h00] = 8'hCC;
    run(8'hFE, 8'h00, 8'd3, 1'b0, 8'h00, 7, 1'b0);
    check("wrap_00", 32'(mem[8'h00]), 32'hAA);
    check("wrap_01", 32'(mem[8'h01]), 32'hBB);
    check("wrap_02", 32'(mem[8'h02]), 32'hAA);

    // Restart pulse while busy is ignored
    run(8'h80, 8'h90, 8'd2, 1'b0, 8'h00, 5, 1'b1);

    // Reset in the third cycle of a four-word copy
    shadow[8'h60] = shadow[8'h50];
    exp_q.push_back({8'h60, shadow[8'h50]});
    busy_cycles = 0; done_pulses = 0;
    src = 8'h50; dst = 8'h60; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_out", {14'd0, busy, done, ram_load, ram_save, ram_address, ram_in}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_done", 32'(done_pulses), 32'd0);
    check("rst_dst0", 32'(mem[8'h60]), 32'(shadow[8'h50]));
    check("rst_dst1", 32'(mem[8'h61]), 32'(shadow[8'h61]));
    check("rst_queue", 32'(exp_q.size()), 32'd0);

`ifdef TC_RAM_COPY_FILL_EN
    run(8'h00, 8'h20, 8'd4, 1'b1, 8'h5A, 5, 1'b0);
    for (int i = 0; i < 4; i++) check("fill_word", 32'(mem[8'h20 + i]), 32'h5A);
`endif

    // Random copies
    for (int k = 0; k < 4; k++) begin
      rs = AW'($urandom_range(0, 255));
      rd = AW'($urandom_range(0, 255));
      rl = AW'($urandom_range(1, 6));
      run(rs, rd, rl, 1'b0, 8'h00, 2 * int'(rl) + 1, 1'b0);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) diffs++;
    check("mem_image", 32'(diffs), 32'd0);
    check("load_save_exclusive", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tc_ram_copy.md
TC_RAM_COPY -- requirements
Module: tc_ram_copy

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width and length width.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request one copy, sampled only in IDLE.
REQ-006 SHALL have port src  input  ADDR_WIDTH  first source address, captured on accepted start.
REQ-007 SHALL have port dst  input  ADDR_WIDTH  first destination address, captured on accepted start.
REQ-008 SHALL have port len  input  ADDR_WIDTH  word count, captured on accepted start.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ram_load  output  1  RAM read strobe.
REQ-012 SHALL have port ram_save  output  1  RAM write strobe.
REQ-013 SHALL have port ram_address  output  ADDR_WIDTH  RAM address.
REQ-014 SHALL have port ram_in  output  DATA_WIDTH  RAM write data.
REQ-015 SHALL have port ram_out  input  DATA_WIDTH  RAM read data, combinationally valid while ram_load is high.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-017 IDLE with start=1 SHALL capture src/dst/len, clear index, and go to READ if len!=0, else to DONE.
REQ-018 READ SHALL drive ram_load=1 and ram_address=src+index, and register ram_out at the ending edge, then go to WRITE.
REQ-019 WRITE SHALL drive ram_save=1, ram_address=dst+index, and ram_in=registered word, then increment index.
REQ-020 WRITE SHALL go to DONE when index+1==len, else to READ.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-022 Throughput SHALL be 2 cycles per word; total latency from start edge to done SHALL be 2*len+1 cycles, or 1 cycle for len=0.
REQ-023 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-024 Copy SHALL proceed in ascending order only; overlapping regions with dst>src are not protected.
REQ-025 ram_load and ram_save SHALL never be high in the same cycle.
REQ-026 In IDLE and DONE, ram_load=0, ram_save=0, ram_address=0 and ram_in=0.
REQ-027 start while not in IDLE SHALL be ignored and SHALL NOT queue.
REQ-028 Changes to src/dst/len after capture SHALL have no effect on a running copy.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE and clear index, captured registers and data register.
REQ-030 During and after reset, busy=0, done=0, ram_load=0, ram_save=0, ram_address=0 and ram_in=0.
REQ-031 Reset mid-copy SHALL abort without a done pulse; words already written remain in RAM.

Configuration
REQ-032 With macro TC_RAM_COPY_FILL_EN defined, the block SHALL add input ports fill (1) and fill_value (DATA_WIDTH), both captured on accepted start.
REQ-033 With TC_RAM_COPY_FILL_EN defined and fill=1, FSM SHALL skip READ: IDLE->WRITE, WRITE->WRITE, writing fill_value at 1 cycle per word; latency SHALL be len+1.
REQ-034 Without TC_RAM_COPY_FILL_EN, the fill ports SHALL be absent and behaviour SHALL be copy-only as above.

Structure
REQ-035 Package tc_ram_copy_pkg SHALL hold the FSM state encoding and default width constants.
REQ-036 One sub-module, tc_ram_copy_addr_gen (index counter, terminal-count compare, wrapped src/dst sums), SHALL be used.

Verification
REQ-037 Preload RAM[0x10..0x12]=0x01,0x02,0x03; start src=0x10 dst=0x40 len=3 -> RAM[0x40..0x42]=0x01,0x02,0x03, done 7 cycles after start, busy high for 7 cycles.
REQ-038 start with len=0 -> done pulses 1 cycle later, and ram_load/ram_save never assert.
REQ-039 src=0xFE dst=0x00 len=3, RAM[0xFE]=0xAA, RAM[0xFF]=0xBB, RAM[0x00]=0xCC -> RAM[0x00..0x02]=0xAA,0xBB,0xAA, demonstrating wrap and the forward-overlap hazard.
REQ-040 Second start pulsed during busy -> ignored; exactly one done pulse is produced.
REQ-041 rst asserted in the 3rd cycle of a len=4 copy -> outputs 0 next edge, no done pulse, and RAM[dst] written, RAM[dst+1] unwritten.
REQ-042 With TC_RAM_COPY_FILL_EN defined: fill=1, fill_value=0x5A, dst=0x20, len=4 -> RAM[0x20..0x23]=0x5A, done 5 cycles after start, and ram_load never high.
